mmc_cmd_engine: RTL and testbench

Command-line engine sitting directly upstream of the MMC CMD pin, alongside the data-path advance logic in mmc_controller. It takes a command index and argument, serialises a 48-bit MMC command frame with a generated CRC7, waits for the card's response start bit, and captures a 48-bit or 136-bit response with CRC7 check and timeout. MMC clocking goes through the shared clk_ctrl tick/done handshake; the engine never generates mmc_clk itself.

---
 rtl/mmc_cmd_engine_if.sv | 24 ++
 rtl/mmc_cmd_engine.sv | 198 +++++++++++++++++++
 tb/tb_mmc_cmd_engine.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc_cmd_engine_if.sv
// Host-side command/response bus of the MMC command engine.
// The host drives the request fields; the engine returns status and response.
interface mmc_cmd_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         crc_chk;
  logic         busy;
  logic         done;
  logic         err_timeout;
  logic         err_crc;
  logic [127:0] resp;

  modport master (
    output start, cmd_index, cmd_arg, resp_type, crc_chk,
    input  busy, done, err_timeout, err_crc, resp
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_type, crc_chk,
    output busy, done, err_timeout, err_crc, resp
  );
endinterface

// File: rtl/mmc_cmd_engine.sv
// MMC CMD-line engine: serialises a 48-bit command with CRC7, then waits for
// and captures a 48/136-bit response, pacing every bit on the clk_ctrl tick/done handshake.
module mmc_cmd_engine #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  mmc_cmd_if.slave host,
  output logic     clk_tick,
  input  logic     clk_done,
  output logic     cmd_o,
  output logic     cmd_oe,
  input  logic     cmd_i
);
  typedef enum logic [2:0] {S_IDLE, S_TX, S_NCR, S_RX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TX_FIRST  = CNT_W'(47);
  localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] R48_LAST  = CNT_W'(46);
  localparam logic [CNT_W-1:0] R136_LAST = CNT_W'(134);

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic             long_q, long_d;
  logic             none_q, none_d;
  logic             crc_chk_q, crc_chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_crc_q, err_crc_d;
  logic [127:0]     resp_q, resp_d;
  logic             clk_tick_q, clk_tick_d;
  logic             cmd_o_q, cmd_o_d;
  logic             cmd_oe_q, cmd_oe_d;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic [47:0]  frame;
  logic [127:0] resp_shift;
  logic [5:0]   tx_next_bit;

  assign frame       = {2'b01, idx_q, arg_q, crc7({2'b01, idx_q, arg_q}), 1'b1};
  assign resp_shift  = {resp_q[126:0], cmd_i};
  assign tx_next_bit = 6'(cnt_q - 1'b1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    arg_d         = arg_q;
    long_d        = long_q;
    none_d        = none_q;
    crc_chk_d     = crc_chk_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_crc_d     = err_crc_q;
    resp_d        = resp_q;
    clk_tick_d    = 1'b0;
    cmd_o_d       = cmd_o_q;
    cmd_oe_d      = cmd_oe_q;

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          idx_d         = host.cmd_index;
          arg_d         = host.cmd_arg;
          long_d        = (host.resp_type == 2'd2);
          none_d        = (host.resp_type == 2'd0);
          crc_chk_d     = host.crc_chk;
          resp_d        = '0;
          err_timeout_d = 1'b0;
          err_crc_d     = 1'b0;
          busy_d        = 1'b1;
          cnt_d         = TX_FIRST;
          cmd_o_d       = 1'b0;
          cmd_oe_d      = 1'b1;
          clk_tick_d    = 1'b1;
          state_d       = S_TX;
        end
      end
      S_TX: begin
        // cnt_q is the index of the bit currently on the line
        if (clk_done) begin
          if (cnt_q == '0) begin
            cmd_oe_d = 1'b0;
            cmd_o_d  = 1'b1;
            if (none_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              clk_tick_d = 1'b1;
              state_d    = S_NCR;
            end
          end else begin
            cnt_d      = cnt_q - 1'b1;
            cmd_o_d    = frame[tx_next_bit];
            clk_tick_d = 1'b1;
          end
        end
      end
      S_NCR: begin
        if (clk_done) begin
          if (!cmd_i) begin
            cnt_d      = '0;
            clk_tick_d = 1'b1;
            state_d    = S_RX;
          end else if (cnt_q == NCR_LAST) begin
            err_timeout_d = 1'b1;
            done_d        = 1'b1;
            state_d       = S_DONE;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            clk_tick_d = 1'b1;
          end
        end
      end
      S_RX: begin
        if (clk_done) begin
          resp_d = resp_shift;
          if (cnt_q == (long_q ? R136_LAST : R48_LAST)) begin
            // CRC covers the consumed start bit (always 0) plus bits 46:8
            if (!long_q && crc_chk_q &&
                (crc7({1'b0, resp_shift[46:8]}) != resp_shift[7:1]))
              err_crc_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            clk_tick_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      arg_q         <= '0;
      long_q        <= 1'b0;
      none_q        <= 1'b0;
      crc_chk_q     <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_crc_q     <= 1'b0;
      resp_q        <= '0;
      clk_tick_q    <= 1'b0;
      cmd_o_q       <= 1'b1;
      cmd_oe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      arg_q         <= arg_d;
      long_q        <= long_d;
      none_q        <= none_d;
      crc_chk_q     <= crc_chk_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_crc_q     <= err_crc_d;
      resp_q        <= resp_d;
      clk_tick_q    <= clk_tick_d;
      cmd_o_q       <= cmd_o_d;
      cmd_oe_q      <= cmd_oe_d;
    end
  end

  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.err_timeout = err_timeout_q;
  assign host.err_crc     = err_crc_q;
  assign host.resp        = resp_q;
  assign clk_tick         = clk_tick_q;
  assign cmd_o            = cmd_o_q;
  assign cmd_oe           = cmd_oe_q;
endmodule

// File: tb/tb_mmc_cmd_engine.sv
// Directed bench for mmc_cmd_engine: a clk_ctrl/card model answers ticks,
// captures the transmitted frame and plays back canned card responses.
module tb_mmc_cmd_engine;
  logic clk;
  logic rst_n;
  logic clk_tick, clk_done, cmd_o, cmd_oe, cmd_i;

  mmc_cmd_if host_if ();

  mmc_cmd_engine #(.NCR_MAX(64), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (host_if),
    .clk_tick (clk_tick),
    .clk_done (clk_done),
    .cmd_o    (cmd_o),
    .cmd_oe   (cmd_oe),
    .cmd_i    (cmd_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0]  tx_cap;
  int           tx_cnt, rx_ticks, tick_viol, done_cnt;
  logic [135:0] card_bits;
  int           card_len, card_idle, card_idx;

  localparam logic [127:0] CID = 128'h1501_0053_454D_3332_4710_A1B2_C3D4_E55F;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk_ctrl + card: each tick completes two cycles later with a one-cycle clk_done
  initial begin : clk_ctrl_model
    clk_done = 1'b0;
    cmd_i    = 1'b1;
    forever begin
      @(negedge clk);
      clk_done = 1'b0;
      if (clk_tick === 1'b1) begin
        if (cmd_oe === 1'b1) begin
          tx_cap = {tx_cap[46:0], cmd_o};
          tx_cnt++;
        end else begin
          rx_ticks++;
          if (card_idle > 0) begin
            cmd_i = 1'b1;
            card_idle--;
          end else if (card_idx < card_len) begin
            cmd_i = card_bits[card_len - 1 - card_idx];
            card_idx++;
          end else begin
            cmd_i = 1'b1;
          end
        end
        repeat (2) begin
          @(negedge clk);
          if (clk_tick === 1'b1) tick_viol++;
        end
        clk_done = 1'b1;
      end
    end
  end

  initial done_cnt = 0;
  always @(negedge clk) if (host_if.done === 1'b1) done_cnt++;

  task automatic prepare(input logic [135:0] bits, input int len, input int idle);
    tx_cap    = '0;
    tx_cnt    = 0;
    rx_ticks  = 0;
    tick_viol = 0;
    card_bits = bits;
    card_len  = len;
    card_idle = idle;
    card_idx  = 0;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] rt, input logic chk);
    @(negedge clk);
    host_if.cmd_index = idx;
    host_if.cmd_arg   = arg;
    host_if.resp_type = rt;
    host_if.crc_chk   = chk;
    host_if.start     = 1'b1;
    @(negedge clk);
    host_if.start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (host_if.done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (host_if.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done never pulsed within 3000 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({host_if.busy, host_if.done, host_if.err_timeout, host_if.err_crc, clk_tick, cmd_o, cmd_oe} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL reset_outputs: busy,done,tmo,crc,tick,cmd_o,cmd_oe got %b expected 0000010",
               {host_if.busy, host_if.done, host_if.err_timeout, host_if.err_crc, clk_tick, cmd_o, cmd_oe});
    end
    n_checks++;
    if (host_if.resp !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h expected 0", host_if.resp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: checked");
  endtask

  task automatic test_cmd0_noresp;
    int d0;
    prepare('0, 0, 0);
    d0 = done_cnt;
    issue(6'd0, 32'h0, 2'd0, 1'b1);
    n_checks++;
    if (host_if.busy !== 1'b1 || cmd_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd0_busy: busy=%b cmd_oe=%b expected 1 1", host_if.busy, cmd_oe);
    end
    wait_done("cmd0");
    n_checks++;
    if (host_if.busy !== 1'b1 || host_if.err_timeout !== 1'b0 || host_if.err_crc !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd0_at_done: busy=%b tmo=%b crc=%b expected 1 0 0",
               host_if.busy, host_if.err_timeout, host_if.err_crc);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_cap !== 48'h400000000095 || tx_cnt !== 48) begin
      n_fail++;
      $display("FAIL cmd0_frame: got %h (%0d periods) expected 400000000095 (48)", tx_cap, tx_cnt);
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || host_if.busy !== 1'b0 || rx_ticks !== 0 || tick_viol !== 0) begin
      n_fail++;
      $display("FAIL cmd0_end: dones=%0d busy=%b rx_ticks=%0d tick_viol=%0d expected 1 0 0 0",
               done_cnt - d0, host_if.busy, rx_ticks, tick_viol);
    end
    $display("cmd0: frame %h, %0d periods", tx_cap, tx_cnt);
  endtask

  task automatic test_cmd17(input logic [47:0] card_resp, input logic exp_crc, input string name);
    prepare({88'h0, card_resp}, 48, 2);
    issue(6'd17, 32'h0, 2'd1, 1'b1);
    wait_done(name);
    n_checks++;
    if (host_if.err_crc !== exp_crc || host_if.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err: crc=%b tmo=%b expected %b 0", name, host_if.err_crc, host_if.err_timeout, exp_crc);
    end
    n_checks++;
    if (host_if.resp !== {80'h0, card_resp}) begin
      n_fail++;
      $display("FAIL %s_resp: got %h expected %h", name, host_if.resp, {80'h0, card_resp});
    end
    @(negedge clk);
    n_checks++;
    if (host_if.busy !== 1'b0 || host_if.done !== 1'b0 || host_if.err_crc !== exp_crc) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b done=%b crc=%b expected 0 0 %b",
               name, host_if.busy, host_if.done, host_if.err_crc, exp_crc);
    end
    n_checks++;
    if (tx_cap !== 48'h510000000055 || rx_ticks !== 50 || tick_viol !== 0) begin
      n_fail++;
      $display("FAIL %s_frame: tx=%h rx_ticks=%0d tick_viol=%0d expected 510000000055 50 0",
               name, tx_cap, rx_ticks, tick_viol);
    end
    $display("%s: resp %h err_crc %b", name, host_if.resp[47:0], host_if.err_crc);
  endtask

  task automatic test_cmd8_timeout;
    prepare('0, 0, 0);
    issue(6'd8, 32'h1AA, 2'd1, 1'b1);
    wait_done("cmd8");
    n_checks++;
    if (host_if.err_timeout !== 1'b1 || host_if.err_crc !== 1'b0 || host_if.resp !== 128'h0) begin
      n_fail++;
      $display("FAIL cmd8_err: tmo=%b crc=%b resp=%h expected 1 0 0",
               host_if.err_timeout, host_if.err_crc, host_if.resp);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (tx_cap !== 48'h48000001AA87 || rx_ticks !== 64) begin
      n_fail++;
      $display("FAIL cmd8_frame: tx=%h ncr_periods=%0d expected 48000001AA87 64", tx_cap, rx_ticks);
    end
    n_checks++;
    if (host_if.err_timeout !== 1'b1 || host_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd8_hold: tmo=%b busy=%b expected 1 0", host_if.err_timeout, host_if.busy);
    end
    $display("cmd8: frame %h, timeout after %0d periods", tx_cap, rx_ticks);
  endtask

  task automatic test_cmd2_r2;
    int k, d0;
    prepare({8'h3F, CID}, 136, 3);
    d0 = done_cnt;
    issue(6'd2, 32'h0, 2'd2, 1'b1);
    n_checks++;
    if (host_if.err_timeout !== 1'b0 || host_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd2_start_clear: tmo=%b busy=%b expected 0 1", host_if.err_timeout, host_if.busy);
    end
    k = 0;
    while (card_idx < 60 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    issue(6'd0, 32'hFFFF_FFFF, 2'd0, 1'b0);
    wait_done("cmd2");
    n_checks++;
    if (host_if.resp !== CID || host_if.err_crc !== 1'b0 || host_if.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd2_resp: got %h crc=%b tmo=%b expected %h 0 0",
               host_if.resp, host_if.err_crc, host_if.err_timeout, CID);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1 || tx_cnt !== 48 || host_if.busy !== 1'b0 || tick_viol !== 0) begin
      n_fail++;
      $display("FAIL cmd2_ignore_start: dones=%0d tx_periods=%0d busy=%b tick_viol=%0d expected 1 48 0 0",
               done_cnt - d0, tx_cnt, host_if.busy, tick_viol);
    end
    $display("cmd2: resp %h", host_if.resp);
  endtask

  task automatic test_reset_mid_tx;
    int k;
    prepare('0, 0, 0);
    issue(6'd0, 32'h0, 2'd0, 1'b0);
    k = 0;
    while (tx_cnt < 28 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_oe !== 1'b0 || cmd_o !== 1'b1 || host_if.busy !== 1'b0 || clk_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_reset: cmd_oe=%b cmd_o=%b busy=%b tick=%b expected 0 1 0 0",
               cmd_oe, cmd_o, host_if.busy, clk_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    prepare('0, 0, 0);
    issue(6'd0, 32'h0, 2'd0, 1'b0);
    wait_done("midtx_retry");
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_cap !== 48'h400000000095 || tx_cnt !== 48) begin
      n_fail++;
      $display("FAIL midtx_retry_frame: got %h (%0d periods) expected 400000000095 (48)", tx_cap, tx_cnt);
    end
    $display("reset_mid_tx: retry frame %h", tx_cap);
  endtask

  initial begin
    host_if.start     = 1'b0;
    host_if.cmd_index = '0;
    host_if.cmd_arg   = '0;
    host_if.resp_type = '0;
    host_if.crc_chk   = 1'b0;
    prepare('0, 0, 0);
    test_reset();
    test_cmd0_noresp();
    test_cmd17(48'h110000090067, 1'b0, "cmd17");
    test_cmd17(48'h110000090167, 1'b1, "cmd17_bad");
    test_cmd8_timeout();
    test_cmd2_r2();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
